// File: rtl/fetch_pkg.sv
// fetch_pkg: types and default widths shared by the fetch stage.
//   fetch_state_t : run-control state of the fetch unit
//   fetch_act_t   : what the fetch stage does this cycle, decided by
//                   pc_next_calc and acted on by the register file in fetch_unit
package fetch_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_START,
        ACT_HALT,
        ACT_STALL,
        ACT_BRANCH,
        ACT_SEQ
    } fetch_act_t;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// pc_next_calc: combinational next-PC and action selection for the fetch unit.
//   state         : current run-control state
//   start/start_addr, stall, branch_*, halt, ir_valid : control inputs
//   pc, ir_pc     : current fetch address and address of the IR contents
//   act           : winning action for this cycle, in priority order
//   pc_next       : PC value to load at the next edge
//   wrap          : a sequential fetch is stepping from the top address to 0
import fetch_pkg::*;

module pc_next_calc #(
    parameter int PC_W = PC_W_DEF
) (
    input  fetch_state_t    state,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            branch_rel,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt,
    input  logic            ir_valid,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] ir_pc,
    output fetch_act_t      act,
    output logic [PC_W-1:0] pc_next,
    output logic            wrap
);

    always_comb begin
        act     = ACT_HOLD;
        pc_next = pc;
        wrap    = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    act     = ACT_START;
                    pc_next = start_addr;
                end
            end
            RUN: begin
                if (halt && ir_valid) begin
                    act = ACT_HALT;
                end else if (stall) begin
                    act = ACT_STALL;
                end else if (branch_taken && ir_valid) begin
                    act = ACT_BRANCH;
                    // A PC_W-bit add of the two's-complement offset equals the
                    // sign-extended sum taken mod 2^PC_W; carry-out is dropped.
                    pc_next = branch_rel ? (ir_pc + branch_target) : branch_target;
                end else begin
                    act     = ACT_SEQ;
                    pc_next = pc + PC_W'(1);
                    wrap    = (pc == {PC_W{1'b1}});
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational instruction memory.
//   clk, rst_n     : clock, synchronous active-low reset
//   start/start_addr : begin execution (accepted in IDLE/HALTED only)
//   stall          : freeze PC and IR
//   branch_taken/branch_rel/branch_target : taken branch resolved on the IR
//   halt           : IR holds a halt instruction
//   pc             : registered fetch address
//   instr_in       : memory data for pc
//   ir/ir_pc/ir_valid : registered instruction, its address, and liveness
//   done           : program halted
//   wrap_err       : sticky, sequential fetch wrapped past the top address
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | fetching one instruction per cycle
// HALTED | halt retired, done asserted, waiting for start
import fetch_pkg::*;

module fetch_unit #(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic               branch_rel,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    output logic               done,
    output logic               wrap_err
);

    fetch_state_t       state, state_nx;
    fetch_act_t         act;
    logic [PC_W-1:0]    pc_next;
    logic               wrap;

    logic [INSTR_W-1:0] ir_nx;
    logic [PC_W-1:0]    ir_pc_nx;
    logic               ir_valid_nx;
    logic               done_nx;
    logic               wrap_err_nx;

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next_calc (
        .state         (state),
        .start         (start),
        .start_addr    (start_addr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .halt          (halt),
        .ir_valid      (ir_valid),
        .pc            (pc),
        .ir_pc         (ir_pc),
        .act           (act),
        .pc_next       (pc_next),
        .wrap          (wrap)
    );

    always_comb begin
        state_nx    = state;
        ir_nx       = ir;
        ir_pc_nx    = ir_pc;
        ir_valid_nx = ir_valid;
        done_nx     = done;
        wrap_err_nx = wrap_err;
        case (act)
            ACT_START: begin
                state_nx    = RUN;
                ir_valid_nx = 1'b0;
                done_nx     = 1'b0;
                wrap_err_nx = 1'b0;
            end
            ACT_HALT: begin
                state_nx    = HALTED;
                ir_valid_nx = 1'b0;
                done_nx     = 1'b1;
            end
            // The word fetched alongside the branch is simply not captured.
            ACT_BRANCH: ir_valid_nx = 1'b0;
            ACT_SEQ: begin
                ir_nx       = instr_in;
                ir_pc_nx    = pc;
                ir_valid_nx = 1'b1;
                wrap_err_nx = wrap_err | wrap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= PC_W'(RESET_PC);
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            done     <= 1'b0;
            wrap_err <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_next;
            ir       <= ir_nx;
            ir_pc    <= ir_pc_nx;
            ir_valid <= ir_valid_nx;
            done     <= done_nx;
            wrap_err <= wrap_err_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic       stall;
    logic       branch_taken;
    logic       branch_rel;
    logic [7:0] branch_target;
    logic       halt;
    logic [7:0] pc;
    logic [8:0] instr_in;
    logic [8:0] ir;
    logic [7:0] ir_pc;
    logic       ir_valid;
    logic       done;
    logic       wrap_err;

    logic [8:0] mem [256];

    always #5 clk = ~clk;

    assign instr_in = mem[pc];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .halt          (halt),
        .pc            (pc),
        .instr_in      (instr_in),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .done          (done),
        .wrap_err      (wrap_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. IDLE and HALTED react identically to inputs, so the
    // model only tracks whether it is running; done distinguishes the rest.
    bit         m_run  = 1'b0;
    logic [7:0] m_pc   = 8'h00;
    logic [8:0] m_ir   = 9'h000;
    logic [7:0] m_irpc = 8'h00;
    logic       m_irv  = 1'b0;
    logic       m_done = 1'b0;
    logic       m_wrap = 1'b0;
    bit         check_en = 1'b0;

    task automatic model_step();
        int t;
        if (!rst_n) begin
            m_run = 0; m_pc = 8'h00; m_ir = 9'h000; m_irpc = 8'h00;
            m_irv = 0; m_done = 0; m_wrap = 0;
        end else if (!m_run) begin
            if (start) begin
                m_pc = start_addr; m_irv = 0; m_done = 0; m_wrap = 0; m_run = 1;
            end
        end else if (halt && m_irv) begin
            m_run = 0; m_irv = 0; m_done = 1;
        end else if (stall) begin
            // everything holds
        end else if (branch_taken && m_irv) begin
            if (branch_rel) begin
                t = int'(m_irpc) + int'($signed(branch_target));
                m_pc = 8'((t + 512) % 256);
            end else begin
                m_pc = branch_target;
            end
            m_irv = 0;
        end else begin
            m_ir   = mem[m_pc];
            m_irpc = m_pc;
            m_irv  = 1;
            if (int'(m_pc) == 255) m_wrap = 1;
            m_pc = 8'((int'(m_pc) + 1) % 256);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pc",       pc,       m_pc);
            chk("model_ir",       ir,       m_ir);
            chk("model_ir_pc",    ir_pc,    m_irpc);
            chk("model_ir_valid", ir_valid, m_irv);
            chk("model_done",     done,     m_done);
            chk("model_wrap_err", wrap_err, m_wrap);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_en = 1'b1;
    endtask

    task automatic idle_inputs();
        start = 0; start_addr = 8'h00; stall = 0; branch_taken = 0;
        branch_rel = 0; branch_target = 8'h00; halt = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
        mem[8'h10] = 9'h001;
        mem[8'h11] = 9'h002;
        mem[8'h12] = 9'h003;

        rst_n = 0;
        idle_inputs();
        tick(); tick();
        rst_n = 1;
        tick();
        chk("reset_pc", pc, 8'h00);
        chk("reset_ir_valid", ir_valid, 1'b0);
        chk("reset_done", done, 1'b0);

        // start at 0x10, sequential stream
        start = 1; start_addr = 8'h10;
        tick();
        start = 0;
        chk("start_pc", pc, 8'h10);
        chk("start_ir_valid", ir_valid, 1'b0);
        tick();
        chk("seq1_pc", pc, 8'h11);
        chk("seq1_ir", ir, 9'h001);
        chk("seq1_ir_pc", ir_pc, 8'h10);
        chk("seq1_ir_valid", ir_valid, 1'b1);
        tick();
        chk("seq2_pc", pc, 8'h12);
        chk("seq2_ir", ir, 9'h002);
        tick();
        chk("seq3_pc", pc, 8'h13);
        chk("seq3_ir", ir, 9'h003);

        // stall for 3 cycles
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 8'h13);
            chk("stall_ir", ir, 9'h003);
            chk("stall_ir_pc", ir_pc, 8'h12);
        end
        stall = 0;
        tick();
        chk("resume_ir", ir, mem[8'h13]);
        chk("resume_ir_pc", ir_pc, 8'h13);
        chk("resume_pc", pc, 8'h14);

        // absolute branch from ir_pc=0x05
        rst_n = 0; tick(); rst_n = 1;
        start = 1; start_addr = 8'h05; tick(); start = 0;
        tick();
        chk("abs_pre_ir_pc", ir_pc, 8'h05);
        branch_taken = 1; branch_rel = 0; branch_target = 8'h40;
        tick();
        branch_taken = 0;
        chk("abs_pc", pc, 8'h40);
        chk("abs_bubble", ir_valid, 1'b0);
        tick();
        chk("abs_ir", ir, mem[8'h40]);
        chk("abs_ir_pc", ir_pc, 8'h40);
        chk("abs_ir_valid", ir_valid, 1'b1);

        // relative backward branch from ir_pc=0x02 by -4
        rst_n = 0; tick(); rst_n = 1;
        start = 1; start_addr = 8'h02; tick(); start = 0;
        tick();
        branch_taken = 1; branch_rel = 1; branch_target = 8'hFC;
        tick();
        branch_taken = 0; branch_rel = 0;
        chk("rel_pc", pc, 8'hFE);
        chk("rel_no_wrap", wrap_err, 1'b0);
        tick();
        chk("rel_ir_pc", ir_pc, 8'hFE);

        // halt, then PC frozen for 10 cycles
        halt = 1;
        tick();
        halt = 0;
        chk("halt_done", done, 1'b1);
        chk("halt_ir_valid", ir_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_pc_frozen", pc, 8'hFF);
            chk("halt_done_held", done, 1'b1);
        end

        // sequential wrap, sticky error
        start = 1; start_addr = 8'hFE; tick(); start = 0;
        chk("wrap_start_pc", pc, 8'hFE);
        chk("wrap_start_done", done, 1'b0);
        tick();
        chk("wrap_pc_ff", pc, 8'hFF);
        chk("wrap_not_yet", wrap_err, 1'b0);
        tick();
        chk("wrap_pc_00", pc, 8'h00);
        chk("wrap_set", wrap_err, 1'b1);
        tick();
        chk("wrap_sticky", wrap_err, 1'b1);
        halt = 1; tick(); halt = 0;
        start = 1; start_addr = 8'h20; tick(); start = 0;
        chk("restart_pc", pc, 8'h20);
        chk("restart_wrap_clr", wrap_err, 1'b0);
        chk("restart_done_clr", done, 1'b0);
        tick();
        chk("restart_ir_valid", ir_valid, 1'b1);
        chk("restart_ir", ir, mem[8'h20]);

        // reset mid-run overrides everything
        rst_n = 0; start = 1; stall = 1; branch_taken = 1; halt = 1;
        start_addr = 8'h77; branch_target = 8'h33;
        tick();
        chk("rst_pc", pc, 8'h00);
        chk("rst_ir", ir, 9'h000);
        chk("rst_ir_pc", ir_pc, 8'h00);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrap", wrap_err, 1'b0);
        rst_n = 1;
        idle_inputs();

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n         = ($urandom_range(199) != 0);
            start         = ($urandom_range(3) == 0);
            start_addr    = 8'($urandom);
            stall         = ($urandom_range(3) == 0);
            branch_taken  = ($urandom_range(3) == 0);
            branch_rel    = 1'($urandom);
            branch_target = 8'($urandom);
            halt          = ($urandom_range(31) == 0);
            tick();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory's 8-bit address. It captures the returned 9-bit instruction into a registered instruction register (IR) for decode. It also handles start, stall, absolute and relative branches, and halt under a small run-control state machine.

## Interface
Parameters:
- PC_W, 8, program counter / instruction memory address width
- INSTR_W, 9, instruction width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  begin execution at start_addr (honoured only in IDLE/HALTED)
- start_addr  in  PC_W  first instruction address
- stall  in  1  downstream stall; freeze PC and IR
- branch_taken  in  1  decode resolves IR instruction as a taken branch/jump
- branch_rel  in  1  1 = target is signed offset from ir_pc; 0 = absolute address
- branch_target  in  PC_W  absolute target or two's-complement offset
- halt  in  1  decode reports IR holds a halt instruction
- pc  out  PC_W  registered fetch address to instruction memory
- instr_in  in  INSTR_W  combinational instruction memory data for current pc
- ir  out  INSTR_W  registered instruction
- ir_pc  out  PC_W  address the IR contents were fetched from
- ir_valid  out  1  IR holds a live instruction
- done  out  1  program halted
- wrap_err  out  1  sticky: sequential fetch wrapped 255 -> 0

## Operation
- States: IDLE, RUN, HALTED. Reset enters IDLE.
- Reset values: pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, done=0, wrap_err=0.
- IDLE/HALTED transitions:
  - start=1: pc<=start_addr, ir_valid<=0, done<=0, wrap_err<=0, go to RUN.
  - Otherwise all outputs hold.
- RUN: actions are evaluated per cycle in the following priority order.
  1. halt && ir_valid: go to HALTED, ir_valid<=0, done<=1, pc holds.
  2. stall: pc, ir, ir_pc, and ir_valid all hold. branch_taken is ignored.
  3. branch_taken && ir_valid: pc<=target, ir_valid<=0. The sequential instruction fetched this cycle is squashed.
     - Absolute: target = branch_target.
     - Relative: target = (ir_pc + branch_target) mod 2^PC_W, with branch_target sign-extended. Branch wrap is silent.
  4. Default: ir<=instr_in, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
     - If pc was 2^PC_W-1, pc wraps to 0 and wrap_err<=1.
- halt and branch_taken are ignored when ir_valid=0.
- start is ignored in RUN.
- Reset mid-operation returns the block to IDLE with reset values in the same edge, regardless of other inputs.

## Timing
- pc is a registered output. instr_in is valid in the same cycle (memory read is combinational).
- Start latency:
  - start sampled at edge N.
  - pc=start_addr after N.
  - ir_valid=1 with ir=Core[start_addr] after N+1.
- Sustained throughput: one instruction per cycle.
- Taken branch costs one bubble: ir_valid=0 for one cycle, then ir=Core[target] one cycle later.
- Halt: done=1 the cycle after halt is sampled. No further IR updates until start.
- No combinational path from any input to any output.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum (IDLE, RUN, HALTED).
  - PC_W/INSTR_W defaults.
- Sub-module pc_next_calc (combinational): computes next pc from state, priority inputs, ir_pc, and branch fields. It also outputs the wrap flag.
- fetch_unit instantiates pc_next_calc and holds all registers and the FSM.

## Test plan
- Reset then start with start_addr=0x10, memory Core[0x10..0x12]=0x001,0x002,0x003:
  - pc=0x10,0x11,0x12,0x13 on successive cycles.
  - ir=0x001,0x002,0x003 from the second cycle after start.
  - ir_valid=1 from the second cycle after start.
- Stall held 3 cycles mid-stream: pc, ir, and ir_pc unchanged for exactly 3 cycles, then the sequence resumes with no lost or duplicated instruction.
- Absolute branch: ir_pc=0x05, branch_taken=1, branch_rel=0, branch_target=0x40 → pc=0x40, one-cycle ir_valid=0, then ir=Core[0x40].
- Relative backward branch: ir_pc=0x02, branch_rel=1, branch_target=0xFC (−4) → pc=0xFE, no wrap_err.
- Sequential wrap: start_addr=0xFE, run 3 cycles → pc 0xFE,0xFF,0x00, wrap_err=1 and sticky. A following start clears it.
- Halt and reset:
  - halt with ir_valid=1 → done=1, ir_valid=0; pc frozen for 10 cycles.
  - start at 0x20 clears done and restarts.
  - rst_n=0 during RUN → next cycle all outputs at reset values.
